// File: rtl/tff_bank_multimode.sv
`default_nettype none
// ============================================================================
//  Module      : tff_bank_multimode
//  Description : Parametrised bank of WIDTH flip-flops with a per-cycle mode
//                select: toggle (T), load (D), JK, or up/down counter.
//                Provides q/qbar, a combinational terminal-count flag and a
//                registered change strobe.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    number of flip-flops in the bank (>= 1)
//    RST_VAL  value loaded into q while reset is asserted
//  Ports
//    clk      in   1      clock, all state updates on posedge
//    rst      in   1      asynchronous, active-low reset
//    en       in   1      1 = apply mode this edge, 0 = hold all state
//    mode     in   2      00 toggle, 01 load, 10 JK, 11 count
//    dir      in   1      count direction (1 = up, 0 = down), count mode only
//    t        in   WIDTH  toggle mask (mode 00) / J vector (mode 10)
//    d        in   WIDTH  load data (mode 01) / K vector (mode 10)
//    q        out  WIDTH  bank state
//    qbar     out  WIDTH  ~q
//    tc       out  1      terminal count (combinational)
//    changed  out  1      one-cycle strobe after an edge that changed q
// ============================================================================
module tff_bank_multimode #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             changed
);

    localparam logic [1:0]       MODE_TOGGLE = 2'b00;
    localparam logic [1:0]       MODE_LOAD   = 2'b01;
    localparam logic [1:0]       MODE_JK     = 2'b10;
    localparam logic [1:0]       MODE_COUNT  = 2'b11;
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    // Cleared by reset and set by the first edge after release; that first
    // edge only arms the bank so a release near an edge never updates q.
    logic             r_armed;
    logic [WIDTH-1:0] w_q_next;

    always_comb begin
        w_q_next = r_q;
        case (mode)
            MODE_TOGGLE: w_q_next = r_q ^ t;
            MODE_LOAD:   w_q_next = d;
            MODE_JK:     w_q_next = (t & ~r_q) | (~d & r_q);
            MODE_COUNT:  w_q_next = dir ? (r_q + C_ONE) : (r_q - C_ONE);
            default:     w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q       <= RST_VAL;
            r_changed <= 1'b0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            r_armed   <= 1'b1;
            r_changed <= 1'b0;
        end else begin
            if (en) begin
                r_q <= w_q_next;
            end
            r_changed <= en & (w_q_next != r_q);
        end
    end

    assign q       = r_q;
    assign qbar    = ~r_q;
    assign changed = r_changed;
    // Flags the state from which the next count edge wraps.
    assign tc      = en & (mode == MODE_COUNT) & (dir ? (&r_q) : ~(|r_q));

endmodule
`default_nettype wire

// File: tb/tb_tff_bank_multimode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tff_bank_multimode
//  Description : Scoreboard bench for tff_bank_multimode. Instance A uses
//                RST_VAL=0000, instance B uses RST_VAL=1001; both share the
//                data inputs and have separate resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_bank_multimode;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] t;
    logic [3:0] d;
    logic [3:0] q_a, qbar_a, q_b, qbar_b;
    logic       tc_a, tc_b, changed_a, changed_b;

    tff_bank_multimode #(.WIDTH(4), .RST_VAL(4'b0000)) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en), .mode(mode), .dir(dir), .t(t), .d(d),
        .q(q_a), .qbar(qbar_a), .tc(tc_a), .changed(changed_a)
    );

    tff_bank_multimode #(.WIDTH(4), .RST_VAL(4'b1001)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en), .mode(mode), .dir(dir), .t(t), .d(d),
        .q(q_b), .qbar(qbar_b), .tc(tc_b), .changed(changed_b)
    );

    typedef struct {
        bit         sel;
        logic [3:0] q;
        logic       ch;
        logic       tc;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   cur_sel = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the bank presents a new state every cycle, so it samples just
    // after each falling edge and retires every expectation queued by then.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            #1;
            while (sb.size() > 0) begin
                r = sb.pop_front();
                chk({r.nm, "_q"},    r.sel ? q_b : q_a,             r.q);
                chk({r.nm, "_qbar"}, r.sel ? qbar_b : qbar_a,       ~r.q);
                chk({r.nm, "_chg"},  {3'b0, r.sel ? changed_b : changed_a}, {3'b0, r.ch});
                chk({r.nm, "_tc"},   {3'b0, r.sel ? tc_b : tc_a},   {3'b0, r.tc});
            end
        end
    end

    task automatic push(input logic [3:0] eq, input logic ech, input logic etc, input string nm);
        exp_t r;
        r.sel = cur_sel;
        r.q   = eq;
        r.ch  = ech;
        r.tc  = etc;
        r.nm  = nm;
        sb.push_back(r);
    endtask

    // At a falling edge: state seen now is (eq, ech); new inputs are applied
    // for the coming rising edge, and etc is tc for those inputs and eq.
    task automatic step(input logic e, input logic [1:0] m, input logic dr,
                        input logic [3:0] tt, input logic [3:0] dd,
                        input logic [3:0] eq, input logic ech, input logic etc,
                        input string nm);
        @(negedge clk);
        en   = e;
        mode = m;
        dir  = dr;
        t    = tt;
        d    = dd;
        push(eq, ech, etc, nm);
    endtask

    initial begin
        int wait_cyc;
        rst_a = 1'b0;
        rst_b = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
        dir   = 1'b0;
        t     = 4'b0101;
        d     = 4'b0000;

        // Reset state on both instances.
        @(negedge clk);
        cur_sel = 1'b0;
        push(4'b0000, 1'b0, 1'b0, "reset_a");
        cur_sel = 1'b1;
        push(4'b1001, 1'b0, 1'b0, "reset_b");
        cur_sel = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Toggle, load, JK.
        step(1, 2'b00, 0, 4'b0101, 4'b0000, 4'b0000, 0, 0, "rel_ignored");
        step(1, 2'b00, 0, 4'b0101, 4'b0000, 4'b0101, 1, 0, "tog1");
        step(1, 2'b01, 0, 4'b0000, 4'b1010, 4'b0000, 1, 0, "tog2");
        step(1, 2'b01, 1, 4'b0000, 4'b1010, 4'b1010, 1, 0, "load");
        step(0, 2'b01, 0, 4'b0000, 4'b0110, 4'b1010, 0, 0, "load_same");
        step(1, 2'b10, 0, 4'b1100, 4'b1010, 4'b1010, 0, 0, "en0_hold");
        step(1, 2'b10, 1, 4'b0011, 4'b0100, 4'b0100, 1, 0, "jk1");
        step(1, 2'b01, 0, 4'b0000, 4'b0000, 4'b0011, 1, 0, "jk2");

        // Count up through wrap; t/d carry junk that must be ignored.
        step(1, 2'b11, 1, 4'b1111, 4'b1111, 4'b0000, 1, 0, "load0");
        for (int k = 1; k < 16; k++) begin
            step(1, 2'b11, 1, 4'(k), ~4'(k), 4'(k), 1, (k == 15), "up");
        end
        step(1, 2'b11, 0, 4'b1010, 4'b0101, 4'b0000, 1, 1, "up_wrap");
        step(1, 2'b01, 0, 4'b0000, 4'b0111, 4'b1111, 1, 0, "down_wrap");

        // Direction flipping every cycle.
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b0111, 1, 0, "load7");
        step(1, 2'b11, 0, 4'b0000, 4'b0000, 4'b1000, 1, 0, "dir_up");
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b0111, 1, 0, "dir_down");
        step(0, 2'b11, 1, 4'b0000, 4'b0000, 4'b1000, 1, 0, "dir_up2");

        // tc gating by en and mode.
        step(1, 2'b01, 0, 4'b0000, 4'b1111, 4'b1000, 0, 0, "en0_hold2");
        step(0, 2'b11, 1, 4'b0000, 4'b0000, 4'b1111, 1, 0, "tc_en0");
        step(1, 2'b00, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, "tc_toggle_mode");
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "tc_up");
        step(1, 2'b01, 0, 4'b0000, 4'b0110, 4'b0000, 1, 0, "wrap2");
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b0110, 1, 0, "load6");

        // Asynchronous reset mid-count on A, then ignored edge and resume.
        @(posedge clk);
        #2;
        rst_a = 1'b0;
        push(4'b0000, 1'b0, 1'b0, "async_rst");
        @(negedge clk);
        #3;
        rst_a = 1'b1;
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "rst_ignored");
        step(0, 2'b00, 0, 4'b0000, 4'b0000, 4'b0001, 1, 0, "resume");

        // Instance B, RST_VAL=1001.
        cur_sel = 1'b1;
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        push(4'b1001, 1'b0, 1'b0, "b_reset");
        @(negedge clk);
        #3;
        rst_b = 1'b1;
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1001, 0, 0, "b_rel");
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1010, 1, 0, "b_up1");
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1011, 1, 0, "b_up2");
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        push(4'b1001, 1'b0, 1'b0, "b_async");
        @(negedge clk);
        #3;
        rst_b = 1'b1;
        step(1, 2'b11, 1, 4'b0000, 4'b0000, 4'b1001, 0, 0, "b_ignored");
        step(0, 2'b00, 0, 4'b0000, 4'b0000, 4'b1010, 1, 0, "b_resume");

        // Drain the scoreboard with a bounded wait.
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
